// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch memory.
// Holds the loader/fetch state encoding and the NOP used to answer faulting fetches.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_mem_ram.sv
// Byte-wide program store: one byte write port, one combinational 4-byte
// little-endian read at the word containing raddr. Contents are never reset.
module instr_byte_ram #(
   parameter int DEPTH_BYTES = 128,
   parameter int AW          = $clog2(DEPTH_BYTES)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [7:0]    mem [DEPTH_BYTES];
   logic [AW-1:0] base;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      base  = raddr & ~AW'(3);
      rdata = {mem[base + AW'(3)], mem[base + AW'(2)], mem[base + AW'(1)], mem[base]};
   end

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory: byte-streamed program loader plus a
// valid/ready fetch port with a registered one-cycle response and fault flag.
module instr_fetch_mem
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH_BYTES = 128,
   parameter int PC_W        = 32,
   parameter int LEN_W       = $clog2(DEPTH_BYTES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_start,
   input  logic             load_valid,
   input  logic [7:0]       load_byte,
   input  logic             load_last,
   output logic             load_ready,
   output logic             load_done,
   output logic [LEN_W-1:0] prog_len,
   input  logic             req_valid,
   input  logic [PC_W-1:0]  req_pc,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic [31:0]      rsp_instr,
   output logic             rsp_fault,
   input  logic             rsp_ready
);

   localparam int              AW       = $clog2(DEPTH_BYTES);
   localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH_BYTES);
   localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH_BYTES - 1);

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               load_done_q, load_done_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_instr_q, rsp_instr_d;
   logic               rsp_fault_q, rsp_fault_d;

   logic               start_new, load_acc, load_end, req_acc, fault;
   logic [PC_W:0]      pc_end;
   logic [31:0]        rd_word;

   instr_byte_ram #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (load_acc),
      .waddr (len_q[AW-1:0]),
      .wdata (load_byte),
      .raddr (req_pc[AW-1:0]),
      .rdata (rd_word)
   );

   // The write pointer and the program length always move together, so one counter serves both.
   always_comb begin
      start_new = load_start && (state_q != LOADING);
      load_acc  = load_valid && load_ready;
      load_end  = load_acc && (load_last || (len_q == LAST_IDX));
      req_acc   = req_valid && req_ready;
      pc_end    = {1'b0, req_pc} + (PC_W+1)'(4);
      fault     = (req_pc[1:0] != 2'b00) || (pc_end > (PC_W+1)'(len_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         len_q       <= '0;
         load_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= '0;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         load_done_q <= load_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY, READY: if (load_start) state_d = LOADING;
         LOADING:      if (load_end)   state_d = READY;
         default:      state_d = EMPTY;
      endcase
   end

   always_comb begin
      load_ready = (state_q == LOADING) && (len_q < DEPTH_L);
      req_ready  = (state_q == READY) && !load_start && (!rsp_valid_q || rsp_ready);
      load_done  = load_done_q;
      prog_len   = len_q;
      rsp_valid  = rsp_valid_q;
      rsp_instr  = rsp_instr_q;
      rsp_fault  = rsp_fault_q;
   end

   // A new load discards any pending response; otherwise the response holds until consumed.
   always_comb begin
      len_d       = len_q;
      load_done_d = load_end;
      rsp_valid_d = rsp_valid_q;
      rsp_instr_d = rsp_instr_q;
      rsp_fault_d = rsp_fault_q;
      if (start_new) begin
         len_d = '0;
      end else if (load_acc) begin
         len_d = len_q + LEN_W'(1);
      end
      if (start_new) begin
         rsp_valid_d = 1'b0;
      end else if (req_acc) begin
         rsp_valid_d = 1'b1;
         rsp_fault_d = fault;
         rsp_instr_d = fault ? NOP_INSTR : rd_word;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: loads, fetches, faults, back-pressure,
// reload over a pending response and reset in the middle of a load.
module tb_instr_fetch_mem;
   import instr_fetch_pkg::*;

   localparam int DEPTH = 128;
   localparam int PC_W  = 32;
   localparam int LEN_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             load_start, load_valid, load_last;
   logic [7:0]       load_byte;
   logic             load_ready, load_done;
   logic [LEN_W-1:0] prog_len;
   logic             req_valid, req_ready;
   logic [PC_W-1:0]  req_pc;
   logic             rsp_valid, rsp_fault, rsp_ready;
   logic [31:0]      rsp_instr;

   int vectors = 0;
   int errors  = 0;

   instr_fetch_mem #(.DEPTH_BYTES(DEPTH), .PC_W(PC_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_byte  (load_byte),
      .load_last  (load_last),
      .load_ready (load_ready),
      .load_done  (load_done),
      .prog_len   (prog_len),
      .req_valid  (req_valid),
      .req_pc     (req_pc),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_instr  (rsp_instr),
      .rsp_fault  (rsp_fault),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Issue one accepted fetch and check the registered response.
   task automatic fetch(input string tag, input logic [31:0] pc,
                        input logic [31:0] exp_instr, input logic exp_fault);
      req_valid = 1'b1;
      req_pc    = pc;
      rsp_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_ins"}, rsp_instr, exp_instr);
      chk({tag, "_flt"}, {31'd0, rsp_fault}, {31'd0, exp_fault});
   endtask

   logic [7:0] prog8 [8] = '{8'hB3, 8'h81, 8'h20, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};

   initial begin
      reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_byte = 8'h00; req_valid = 1'b1; req_pc = '0; rsp_ready = 1'b1;
      step();
      step();
      chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_load_done",  {31'd0, load_done},  32'd0);
      chk("rst_prog_len",   32'(prog_len),       32'd0);
      chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
      chk("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      chk("rst_rsp_instr",  rsp_instr,           32'd0);
      chk("rst_rsp_fault",  {31'd0, rsp_fault},  32'd0);
      reset = 1'b0;
      req_valid = 1'b0;

      // 8-byte program with load_last on the final byte
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("ld8_ready", {31'd0, load_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         push(prog8[i], i == 7);
         if (i == 6) chk("ld8_no_early_done", {31'd0, load_done}, 32'd0);
      end
      chk("ld8_done", {31'd0, load_done}, 32'd1);
      chk("ld8_len", 32'(prog_len), 32'd8);
      chk("ld8_state", 32'(dut.state_q), 32'(READY));
      step();
      chk("ld8_done_once", {31'd0, load_done}, 32'd0);

      fetch("pc0", 32'd0, 32'h002081B3, 1'b0);
      fetch("pc4", 32'd4, 32'h00000513, 1'b0);
      fetch("pc2", 32'd2, NOP_INSTR, 1'b1);
      fetch("pc8", 32'd8, NOP_INSTR, 1'b1);
      step();
      chk("idle_rsp_drop", {31'd0, rsp_valid}, 32'd0);

      // back-pressure: response holds while rsp_ready is low
      req_valid = 1'b1; req_pc = 32'd0; rsp_ready = 1'b0;
      step();
      req_pc = 32'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
         chk("hold_instr", rsp_instr, 32'h002081B3);
         step();
      end
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_instr_end", rsp_instr, 32'h002081B3);
      rsp_ready = 1'b1;
      #1;
      chk("release_req_ready", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("release_instr", rsp_instr, 32'h00000513);

      // reload while a response is pending, with a competing request
      req_valid = 1'b1; req_pc = 32'd0; load_start = 1'b1;
      #1;
      chk("reload_req_ready", {31'd0, req_ready}, 32'd0);
      step();
      load_start = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      chk("reload_rsp_drop", {31'd0, rsp_valid}, 32'd0);
      chk("reload_state", 32'(dut.state_q), 32'(LOADING));
      chk("reload_len", 32'(prog_len), 32'd0);

      // fill the whole memory without load_last
      for (int i = 0; i < DEPTH; i++) begin
         push(8'(i), 1'b0);
         if (i == DEPTH - 2) begin
            chk("full_len127", 32'(prog_len), 32'd127);
            chk("full_ready127", {31'd0, load_ready}, 32'd1);
         end
      end
      chk("full_done", {31'd0, load_done}, 32'd1);
      chk("full_len", 32'(prog_len), 32'd128);
      chk("full_load_ready", {31'd0, load_ready}, 32'd0);
      chk("full_state", 32'(dut.state_q), 32'(READY));
      push(8'hEE, 1'b1);
      chk("ready_ignores_load", 32'(prog_len), 32'd128);

      fetch("f124", 32'd124, 32'h7F7E7D7C, 1'b0);
      fetch("f128", 32'd128, NOP_INSTR, 1'b1);
      fetch("fhuge", 32'hFFFF_FFFC, NOP_INSTR, 1'b1);

      // back-to-back fetches, one per cycle; old program overwritten from byte 0
      req_valid = 1'b1; req_pc = 32'd0; rsp_ready = 1'b1;
      step();
      chk("b2b0_instr", rsp_instr, 32'h03020100);
      req_pc = 32'd4;
      #1;
      chk("b2b1_req_ready", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
      chk("b2b1_valid", {31'd0, rsp_valid}, 32'd1);
      chk("b2b1_instr", rsp_instr, 32'h07060504);

      // reset in the middle of a load
      step();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i), 1'b0);
      chk("mid_len3", 32'(prog_len), 32'd3);
      reset = 1'b1; load_valid = 1'b1; load_byte = 8'h55; req_valid = 1'b1;
      step();
      load_valid = 1'b0;
      chk("midrst_state", 32'(dut.state_q), 32'(EMPTY));
      chk("midrst_len", 32'(prog_len), 32'd0);
      chk("midrst_load_ready", {31'd0, load_ready}, 32'd0);
      chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      step();
      chk("empty_req_ready", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
